chan_sel_mux: RTL

Parametrised N-channel, WIDTH-bit registered channel selector with valid/ready handshaking. It generalises the team's 2:1 select/XOR-gate style into a pipelined block with two modes. In fixed-select mode it forwards one software-chosen channel. In round-robin mode it arbitrates fairly among all requesting channels. It sits between parallel producer channels and a single downstream consumer, and emits the channel index and an even-parity bit with each word.

---
 rtl/chan_sel_mux.sv | 126 ++++++++++++
 1 files changed

// File: rtl/chan_sel_mux.sv
// N-channel registered channel selector with valid/ready handshake.
// Mode 0 forwards a fixed channel; mode 1 arbitrates round-robin after the last winner.
module chan_sel_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_parity,
  input  logic                      out_ready
);

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  logic               grant_vld_s;
  logic [SEL_W-1:0]   grant_idx_s;
  logic               load_en_s;
  logic               xfer_s;
  logic [WIDTH-1:0]   grant_data_s;

  logic               out_valid_d,  out_valid_q;
  logic [WIDTH-1:0]   out_data_d,   out_data_q;
  logic [SEL_W-1:0]   out_chan_d,   out_chan_q;
  logic               out_parity_d, out_parity_q;
  logic [SEL_W-1:0]   ptr_d,        ptr_q;

  // Grant selection: fixed channel or first requester after ptr (wrapping)
  always_comb begin
    int cand;
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand        = 0;
    case (mode)
      1'b0: begin
        if ((int'(sel) < CHANNELS) && in_valid[sel]) begin
          grant_vld_s = 1'b1;
          grant_idx_s = sel;
        end else begin
          grant_vld_s = 1'b0;
        end
      end
      1'b1: begin
        for (int k = 1; k <= CHANNELS; k++) begin
          cand = (int'(ptr_q) + k) % CHANNELS;
          if (!grant_vld_s && in_valid[cand]) begin
            grant_vld_s = 1'b1;
            grant_idx_s = SEL_W'(cand);
          end else begin
            grant_vld_s = grant_vld_s;
          end
        end
      end
      default: begin
        grant_vld_s = 1'b0;
      end
    endcase
  end

  assign load_en_s    = !out_valid_q || out_ready;
  assign xfer_s       = rst_n && load_en_s && grant_vld_s;
  assign grant_data_s = in_data[int'(grant_idx_s)*WIDTH +: WIDTH];

  // One-hot accept toward the granted producer only
  always_comb begin
    in_ready = '0;
    if (xfer_s) begin
      in_ready[grant_idx_s] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output register next state: load, drain, or hold
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_parity_d = out_parity_q;
    ptr_d        = ptr_q;
    if (xfer_s) begin
      out_valid_d  = 1'b1;
      out_data_d   = grant_data_s;
      out_chan_d   = grant_idx_s;
      out_parity_d = even_parity(grant_data_s);
      ptr_d        = mode ? grant_idx_s : ptr_q;
    end else if (load_en_s) begin
      out_valid_d  = 1'b0;
    end else begin
      out_valid_d  = out_valid_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_parity_q <= 1'b0;
      ptr_q        <= SEL_W'(CHANNELS - 1);
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_parity_q <= out_parity_d;
      ptr_q        <= ptr_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_chan   = out_chan_q;
  assign out_parity = out_parity_q;

endmodule
